// File: rtl/counter_arbiter_pkg.sv
// Shared types and sizing helpers for the counter arbiter.
// Holds the FSM state encoding and the requester-index width rule.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  localparam int WIDTH_DEFAULT = 8;
  localparam int N_REQ_DEFAULT = 4;

  // A single requester still needs a one-bit index so the ports stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEFAULT = idx_width(N_REQ_DEFAULT);

endpackage

// File: rtl/counter_arbiter_if.sv
// Requester-side valid/ready bus shared by all requesters of the arbiter.
// Addend of requester i lives at req_value[i*WIDTH +: WIDTH].
interface counter_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_value;
  logic [N_REQ-1:0]       req_ready;

  modport master (output req_valid, output req_value, input  req_ready);
  modport slave  (input  req_valid, input  req_value, output req_ready);
endinterface

// File: rtl/counter_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping at N_REQ.
module rr_pick
  import counter_ctrl_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEFAULT,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] k;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    any_o = 1'b0;
    idx_o = '0;
    k     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = IDX_W'((int'(ptr_i) + i) % N_REQ);
      if (!any_o && req_i[k]) begin
        any_o = 1'b1;
        idx_o = k;
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin front end for a shared accumulating counter: grants one
// requester per two cycles, sequences clears and clamps the sum at all-ones.
module counter_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEFAULT,
  parameter  int N_REQ = N_REQ_DEFAULT,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  counter_arbiter_if.slave     req_if,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     ctr_count,
  output logic                 ctr_rst,
  output logic                 ctr_ld,
  output logic [WIDTH-1:0]     ctr_v,
  output logic [IDX_W-1:0]     gnt_id,
  output logic                 sat
);

  state_e           state_q;
  logic             ctr_rst_q, ctr_ld_q, sat_q, clr_pend_q;
  logic [WIDTH-1:0] ctr_v_q;
  logic [N_REQ-1:0] ready_q;
  logic [IDX_W-1:0] gnt_q, ptr_q;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [WIDTH-1:0] pick_val;
  logic [WIDTH:0]   sum;
  logic             clamp;
  logic [WIDTH-1:0] v_d;
  logic [IDX_W-1:0] ptr_d;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i (req_if.req_valid),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  // The carry out of a WIDTH+1 bit add flags that the addend would wrap.
  assign pick_val = req_if.req_value[int'(pick_idx)*WIDTH +: WIDTH];
  assign sum      = {1'b0, ctr_count} + {1'b0, pick_val};
  assign clamp    = sum[WIDTH];
  assign v_d      = clamp ? ({WIDTH{1'b1}} - ctr_count) : pick_val;
  assign ptr_d    = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

  // NOTE: state and outputs are registers, so they use non-blocking
  // assignments; all of them reset asynchronously, there is no memory here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CLEAR;
      ctr_rst_q  <= 1'b1;
      ctr_ld_q   <= 1'b0;
      ctr_v_q    <= '0;
      ready_q    <= '0;
      gnt_q      <= '0;
      ptr_q      <= '0;
      sat_q      <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          // A clr arriving here is absorbed by the clear already under way.
          ctr_rst_q  <= 1'b0;
          sat_q      <= 1'b0;
          clr_pend_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        S_IDLE: begin
          if (clr || clr_pend_q) begin
            ctr_rst_q <= 1'b1;
            state_q   <= S_CLEAR;
          end else if (pick_any) begin
            gnt_q    <= pick_idx;
            ctr_v_q  <= v_d;
            ptr_q    <= ptr_d;
            ctr_ld_q <= 1'b1;
            ready_q  <= N_REQ'(1) << pick_idx;
            if (clamp) sat_q <= 1'b1;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ctr_ld_q <= 1'b0;
          ready_q  <= '0;
          if (clr) clr_pend_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign ctr_rst          = ctr_rst_q;
  assign ctr_ld           = ctr_ld_q;
  assign ctr_v            = ctr_v_q;
  assign gnt_id           = gnt_q;
  assign sat              = sat_q;
  assign req_if.req_ready = ready_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioural shared counter.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_counter_arbiter;
  import counter_ctrl_pkg::*;

  localparam int WIDTH = 8;
  localparam int N_REQ = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic [WIDTH-1:0] ctr_count;
  logic             ctr_rst, ctr_ld, sat;
  logic [WIDTH-1:0] ctr_v;
  logic [1:0]       gnt_id;

  int n_checks = 0;
  int n_errors = 0;

  counter_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  counter_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_if    (bus),
    .clr       (clr),
    .ctr_count (ctr_count),
    .ctr_rst   (ctr_rst),
    .ctr_ld    (ctr_ld),
    .ctr_v     (ctr_v),
    .gnt_id    (gnt_id),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  // Shared counter: synchronous clear has priority over add.
  always_ff @(posedge clk) begin
    if (ctr_rst)     ctr_count <= '0;
    else if (ctr_ld) ctr_count <= ctr_count + ctr_v;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [WIDTH-1:0] val);
    bus.req_valid[i] = v;
    bus.req_value[i*WIDTH +: WIDTH] = val;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    clr           = 1'b0;
    bus.req_valid = '0;
    bus.req_value = '0;

    // 1. Reset
    tick(); tick(); tick();
    rst_n = 1'b1;
    check("rst_ctr_rst_first", ctr_rst, 1);
    tick();
    check("rst_ctr_rst_idle", ctr_rst, 0);
    check("rst_ld", ctr_ld, 0);
    check("rst_v", ctr_v, 0);
    check("rst_ready", bus.req_ready, 0);
    check("rst_gnt", gnt_id, 0);
    check("rst_sat", sat, 0);
    check("rst_count", ctr_count, 0);

    // 2. Single request from requester 2
    set_req(2, 1'b1, 8'd5);
    tick();
    check("single_ld", ctr_ld, 1);
    check("single_v", ctr_v, 5);
    check("single_ready", bus.req_ready, 4'b0100);
    check("single_gnt", gnt_id, 2);
    set_req(2, 1'b0, 8'd0);
    tick();
    check("single_count", ctr_count, 5);
    check("single_ld_off", ctr_ld, 0);
    check("single_ready_off", bus.req_ready, 0);

    // 3. All four valid, each drops after its ready
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 8'(i + 1));
    for (int i = 0; i < N_REQ; i++) begin
      tick();
      check($sformatf("all_gnt%0d", i), gnt_id, i);
      check($sformatf("all_ready%0d", i), bus.req_ready, 32'd1 << i);
      set_req(i, 1'b0, 8'd0);
      tick();
    end
    check("all_count", ctr_count, 10);

    // 4. Fairness between requesters 0 and 1 held valid
    set_req(0, 1'b1, 8'd1);
    set_req(1, 1'b1, 8'd1);
    for (int g = 0; g < 6; g++) begin
      tick();
      check($sformatf("fair_gnt%0d", g), gnt_id, g % 2);
      tick();
    end
    set_req(0, 1'b0, 8'd0);
    set_req(1, 1'b0, 8'd0);
    check("fair_count", ctr_count, 16);

    // 5. Saturation and clear
    do_reset();
    set_req(0, 1'b1, 8'd250);
    tick();
    set_req(0, 1'b1, 8'd10);
    tick();
    check("sat_pre_count", ctr_count, 250);
    check("sat_pre_flag", sat, 0);
    tick();
    check("sat_clamp_v", ctr_v, 5);
    check("sat_flag", sat, 1);
    set_req(0, 1'b1, 8'd1);
    tick();
    check("sat_count_max", ctr_count, 255);
    tick();
    check("sat_full_v", ctr_v, 0);
    check("sat_full_ready", bus.req_ready, 4'b0001);
    check("sat_sticky", sat, 1);
    set_req(0, 1'b0, 8'd0);
    tick();
    check("sat_count_held", ctr_count, 255);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("sat_clr_rst", ctr_rst, 1);
    tick();
    check("sat_clr_count", ctr_count, 0);
    check("sat_clr_flag", sat, 0);

    // Zero addend still completes the handshake
    set_req(2, 1'b1, 8'd0);
    tick();
    check("zero_ready", bus.req_ready, 4'b0100);
    check("zero_v", ctr_v, 0);
    set_req(2, 1'b0, 8'd0);
    tick();
    check("zero_count", ctr_count, 0);

    // 6a. clr during S_ISSUE is deferred until the load completes
    set_req(1, 1'b1, 8'd7);
    tick();
    check("clri_ld", ctr_ld, 1);
    check("clri_v", ctr_v, 7);
    clr = 1'b1;
    set_req(1, 1'b0, 8'd0);
    tick();
    clr = 1'b0;
    check("clri_count", ctr_count, 7);
    check("clri_rst_wait", ctr_rst, 0);
    tick();
    check("clri_rst", ctr_rst, 1);
    tick();
    check("clri_rst_end", ctr_rst, 0);
    check("clri_count0", ctr_count, 0);
    tick();
    check("clri_single", ctr_rst, 0);

    // clr held into S_CLEAR is absorbed
    set_req(0, 1'b1, 8'd3);
    tick();
    set_req(0, 1'b0, 8'd0);
    tick();
    check("abs_count", ctr_count, 3);
    clr = 1'b1;
    tick();
    check("abs_rst", ctr_rst, 1);
    tick();
    clr = 1'b0;
    check("abs_rst_end", ctr_rst, 0);
    tick();
    check("abs_no_second", ctr_rst, 0);
    check("abs_count0", ctr_count, 0);

    // 6b. Async reset during S_ISSUE drops the load
    set_req(3, 1'b1, 8'd9);
    tick();
    check("arst_ld_before", ctr_ld, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ld", ctr_ld, 0);
    check("arst_ready", bus.req_ready, 0);
    check("arst_ctr_rst", ctr_rst, 1);
    check("arst_v", ctr_v, 0);
    check("arst_gnt", gnt_id, 0);
    set_req(3, 1'b0, 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_count", ctr_count, 0);
    check("arst_idle_ready", bus.req_ready, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
